// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic [2:0] UART_LAST_BIT = 3'(UART_DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while running and flags the
// last cycle of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last   = (r_cnt == LAST_CNT);
  assign bit_tick = run && w_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || !run || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO consumer that pops one byte at a time and sends it as a UART 8N1 frame.
//
// state | meaning
// IDLE  | line high, waiting for enable and a non-empty FIFO
// POP   | one-cycle read strobe to the FIFO
// LOAD  | capture the registered FIFO output into the shift register
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); last cycle decides between POP and IDLE
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  state_t     r_state, w_state_next;
  logic [7:0] r_shreg, w_shreg_next;
  logic [2:0] r_bit_idx, w_bit_idx_next;
  logic       r_tx, w_tx_next;
  logic       w_run, w_clear, w_bit_tick, w_can_start;

  assign w_run       = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign w_clear     = (r_state == LOAD);
  assign w_can_start = enable && !fifo_empty;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock   (clock),
    .reset   (reset),
    .run     (w_run),
    .clear   (w_clear),
    .bit_tick(w_bit_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_tx      <= UART_IDLE_LEVEL;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_idx_next = r_bit_idx;
    unique case (r_state)
      IDLE:  if (w_can_start) w_state_next = POP;
      POP:   w_state_next = LOAD;
      LOAD: begin
        w_shreg_next = fifo_data;
        w_state_next = START;
      end
      START: if (w_bit_tick) begin
        w_state_next   = DATA;
        w_bit_idx_next = '0;
      end
      DATA: if (w_bit_tick) begin
        w_shreg_next = {1'b0, r_shreg[7:1]};
        if (r_bit_idx == UART_LAST_BIT) begin
          w_state_next = STOP;
        end else begin
          w_bit_idx_next = r_bit_idx + 1'b1;
        end
      end
      STOP:  if (w_bit_tick) w_state_next = w_can_start ? POP : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Line level is decided from the next state so tx changes on the same edge as the FSM.
  always_comb begin
    w_tx_next = UART_IDLE_LEVEL;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shreg_next[0];
      default: w_tx_next = UART_IDLE_LEVEL;
    endcase
  end

  assign tx         = r_tx;
  assign fifo_read  = (r_state == POP);
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == STOP) && w_bit_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT,
// a line monitor decodes frames and compares them with the bytes pushed.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read, tx, busy, frame_done;

  logic       push_en = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] fq[$];
  logic [7:0] sb[$];
  int         gaps[$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0, pops = 0, starts = 0, last_done = -1000;
  logic smp [0:FL-1];
  logic fdn [0:FL-1];

  // Auxiliary instances for bit-period scaling
  logic       a2_full = 1'b0, a2_load = 1'b0, a16_full = 1'b0, a16_load = 1'b0;
  logic [7:0] a2_data = 8'h00, a16_data = 8'h00;
  logic       a2_read, a2_tx, a2_busy, a2_done;
  logic       a16_read, a16_tx, a16_busy, a16_done;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read(fifo_read), .tx(tx), .busy(busy),
    .frame_done(frame_done));

  fifo_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .clock(clock), .reset(reset), .enable(1'b1), .fifo_empty(!a2_full),
    .fifo_data(a2_data), .fifo_read(a2_read), .tx(a2_tx), .busy(a2_busy),
    .frame_done(a2_done));

  fifo_uart_tx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clock(clock), .reset(reset), .enable(1'b1), .fifo_empty(!a16_full),
    .fifo_data(a16_data), .fifo_read(a16_read), .tx(a16_tx), .busy(a16_busy),
    .frame_done(a16_done));

  // fifo_32 behaviour: registered dataout, zero unless the previous cycle popped.
  always @(posedge clock) begin
    if (fifo_read && fq.size() > 0) fifo_data <= fq.pop_front();
    else fifo_data <= 8'h00;
    if (push_en) fq.push_back(push_data);
    fifo_empty <= (fq.size() == 0);
  end

  always @(posedge clock) begin
    a2_data  <= (a2_read && a2_full) ? 8'h01 : 8'h00;
    a16_data <= (a16_read && a16_full) ? 8'h01 : 8'h00;
    if (a2_read) a2_full <= 1'b0; else if (a2_load) a2_full <= 1'b1;
    if (a16_read) a16_full <= 1'b0; else if (a16_load) a16_full <= 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout at cycle %0d", name, cyc);
  endtask

  // Line monitor: decodes each frame at mid-bit and checks timing and order.
  initial begin : monitor
    int   t0;
    bit   aborted, stable, fd_ok, bz, rd_in;
    logic [7:0] dec;
    logic [7:0] exp_b;
    forever begin
      @(negedge clock);
      if (reset) continue;
      if (fifo_read) begin
        pops++;
        check("read_while_empty", fifo_empty, 0);
      end
      if (tx === 1'b0) begin
        starts++;
        t0 = cyc;
        gaps.push_back(t0 - last_done - 1);
        aborted = 0; bz = 1; rd_in = 0;
        for (int i = 0; i < FL; i++) begin
          if (i > 0) begin
            @(negedge clock);
            if (reset) begin aborted = 1; break; end
            if (fifo_read) begin pops++; rd_in = 1; end
          end
          smp[i] = tx;
          fdn[i] = frame_done;
          if (busy !== 1'b1) bz = 0;
        end
        if (!aborted) begin
          last_done = cyc;
          stable = 1; fd_ok = 1;
          for (int i = 0; i < FL; i++) begin
            if (smp[i] !== smp[(i / CPB) * CPB + CPB / 2]) stable = 0;
            if (fdn[i] !== (i == FL - 1)) fd_ok = 0;
          end
          for (int b = 0; b < 8; b++) dec[b] = smp[(b + 1) * CPB + CPB / 2];
          check("start_bit", smp[CPB / 2], 0);
          check("stop_bit", smp[9 * CPB + CPB / 2], 1);
          check("bit_stable", stable, 1);
          check("frame_done_at_end", fd_ok, 1);
          check("busy_in_frame", bz, 1);
          check("read_in_frame", rd_in, 0);
          if (sb.size() > 0) begin
            exp_b = sb.pop_front();
            check("frame_data", dec, exp_b);
          end else begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_unexpected: got byte %0d expected no frame", dec);
          end
        end
      end else begin
        check("idle_frame_done", frame_done, 0);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clock);
    push_en   = 1'b1;
    push_data = b;
    sb.push_back(b);
    @(negedge clock);
    push_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clock);
      if (!busy && fifo_empty && sb.size() == 0 && !push_en) break;
    end
    if (k == budget) timeout(name);
  endtask

  task automatic wait_tx_low(input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clock);
      if (tx === 1'b0) break;
    end
    if (k == budget) timeout(name);
  endtask

  // Sends 0x01 on an auxiliary instance: start-bit length equals the bit period.
  task automatic aux_measure(input bit sel16, input int cpb);
    int t0, lo, k;
    @(negedge clock);
    if (sel16) a16_load = 1'b1; else a2_load = 1'b1;
    @(negedge clock);
    a16_load = 1'b0; a2_load = 1'b0;
    for (k = 0; k < 50; k++) begin
      if ((sel16 ? a16_tx : a2_tx) === 1'b0) break;
      @(negedge clock);
    end
    if (k == 50) begin timeout("aux_start"); return; end
    t0 = cyc;
    lo = 0;
    while ((sel16 ? a16_tx : a2_tx) === 1'b0 && lo < 200) begin
      lo++;
      @(negedge clock);
    end
    check(sel16 ? "bit_period_16" : "bit_period_2", lo, cpb);
    for (k = 0; k < 400; k++) begin
      if ((sel16 ? a16_done : a2_done) === 1'b1) break;
      @(negedge clock);
    end
    if (k == 400) begin timeout("aux_done"); return; end
    check(sel16 ? "frame_len_16" : "frame_len_2", cyc - t0 + 1, 10 * cpb);
  endtask

  initial begin : stimulus
    int p0, s0;
    bit idle_ok;
    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;

    // single byte
    enable = 1'b1;
    p0 = pops;
    push_byte(8'hA5);
    wait_idle(200, "single_idle");
    check("single_pops", pops - p0, 1);

    // back-to-back
    p0 = pops;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    wait_idle(400, "b2b_idle");
    check("b2b_pops", pops - p0, 3);
    check("b2b_gap1", gaps[gaps.size() - 2], 2);
    check("b2b_gap2", gaps[gaps.size() - 1], 2);

    // enable drop during first frame's data bits
    p0 = pops;
    push_byte(8'h96);
    push_byte(8'h4B);
    wait_tx_low(50, "endrop_start");
    repeat (8) @(negedge clock);
    enable = 1'b0;
    repeat (FL + 20) @(negedge clock);
    check("endrop_pops", pops - p0, 1);
    check("endrop_busy", busy, 0);
    check("endrop_pending", sb.size(), 1);
    check("endrop_fifo_empty", fifo_empty, 0);
    enable = 1'b1;
    wait_idle(200, "endrop_idle");
    check("endrop_resume_pops", pops - p0, 2);

    // asynchronous reset in the middle of DATA
    push_byte(8'h5A);
    wait_tx_low(50, "rst_start");
    repeat (6) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_read", fifo_read, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sb.delete();
    idle_ok = 1;
    repeat (20) begin
      @(negedge clock);
      if (busy !== 1'b0 || tx !== 1'b1 || fifo_read !== 1'b0) idle_ok = 0;
    end
    check("post_rst_idle", idle_ok, 1);

    // stress: fill to 32 with enable low, then drain
    enable = 1'b0;
    p0 = pops;
    s0 = starts;
    for (int i = 0; i < 32; i++) push_byte(8'($urandom_range(0, 255)));
    repeat (5) @(negedge clock);
    check("full_no_pop", pops - p0, 0);
    check("full_busy", busy, 0);
    enable = 1'b1;
    wait_idle(32 * (FL + 4) + 100, "stress_idle");
    check("stress_pops", pops - p0, 32);
    check("stress_frames", starts - s0, 32);
    check("stress_empty", fifo_empty, 1);

    // bit-period scaling
    aux_measure(1'b0, 2);
    aux_measure(1'b1, 16);

    repeat (5) @(negedge clock);
    check("pops_eq_starts", pops, starts);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
